// File: rtl/lb_arbiter.sv
// Round-robin arbiter sharing one regmap local bus between NREQ masters.
// One transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> RESP -> IDLE.
module lb_arbiter #(
  parameter int NREQ     = 2,
  parameter int LBCWIDTH = 8,
  parameter int LBAWIDTH = 24,
  parameter int LBDWIDTH = 32,
  parameter int RDLAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*LBCWIDTH-1:0]   req_cmd,
  input  logic [NREQ*LBAWIDTH-1:0]   req_addr,
  input  logic [NREQ*LBDWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            resp_valid,
  output logic [LBDWIDTH-1:0]        resp_rdata,
  output logic                       lb_stb,
  output logic [LBCWIDTH-1:0]        lb_cmd,
  output logic [LBAWIDTH-1:0]        lb_addr,
  output logic [LBDWIDTH-1:0]        lb_wdata,
  input  logic [LBDWIDTH-1:0]        lb_rdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_nx;
  logic [GW-1:0]         last, grant, pick, cand;
  logic                  found;
  logic [CW-1:0]         cnt;
  logic [LBCWIDTH-1:0]   sel_cmd;
  logic [LBAWIDTH-1:0]   sel_addr;
  logic [LBDWIDTH-1:0]   sel_wdata;
  logic                  stb_nx;
  logic [NREQ-1:0]       ready_nx, resp_nx;
  logic [LBDWIDTH-1:0]   rdata_nx;

  // Search starts one past the last grant so simultaneous requesters rotate.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == pick) begin
        sel_cmd   = req_cmd[i*LBCWIDTH +: LBCWIDTH];
        sel_addr  = req_addr[i*LBAWIDTH +: LBAWIDTH];
        sel_wdata = req_wdata[i*LBDWIDTH +: LBDWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = lb_cmd[0] ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; all outputs are flops.
  always_comb begin
    stb_nx   = 1'b0;
    ready_nx = '0;
    resp_nx  = '0;
    rdata_nx = '0;
    if (state == IDLE && found) begin
      stb_nx         = 1'b1;
      ready_nx[pick] = 1'b1;
    end
    if (state_nx == RESP) resp_nx[grant] = 1'b1;
    if (state == WAIT && cnt == '0) rdata_nx = lb_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= GW'(NREQ - 1);
      grant      <= '0;
      cnt        <= '0;
      lb_stb     <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      lb_cmd     <= '0;
      lb_addr    <= '0;
      lb_wdata   <= '0;
    end else begin
      lb_stb     <= stb_nx;
      req_ready  <= ready_nx;
      resp_valid <= resp_nx;
      resp_rdata <= rdata_nx;
      if (state == IDLE && found) begin
        grant    <= pick;
        last     <= pick;
        lb_cmd   <= sel_cmd;
        lb_addr  <= sel_addr;
        lb_wdata <= sel_wdata;
      end
      // Counter reaches 0 in the last of exactly RDLAT wait cycles.
      if (state == ISSUE)                  cnt <= CW'(RDLAT - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_lb_arbiter.sv
// Bench for lb_arbiter: randomized masters, transaction-level reference model,
// expected strobes/responses queued per cycle and checked by a negedge monitor.
module tb_lb_arbiter;
  localparam int NREQ  = 3;
  localparam int CW    = 8;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int RDLAT = 3;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [7:0]    m;
    logic [CW-1:0] cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } stb_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [7:0]    m;
    logic [DW-1:0] data;
  } resp_t;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CW-1:0]   req_cmd;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [DW-1:0]        resp_rdata;
  logic                 lb_stb;
  logic [CW-1:0]        lb_cmd;
  logic [AW-1:0]        lb_addr;
  logic [DW-1:0]        lb_wdata;
  logic [DW-1:0]        lb_rdata;

  lb_arbiter #(
    .NREQ(NREQ), .LBCWIDTH(CW), .LBAWIDTH(AW), .LBDWIDTH(DW), .RDLAT(RDLAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .lb_stb(lb_stb), .lb_cmd(lb_cmd), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_rdata(lb_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  stb_t          stb_q[$];
  resp_t         resp_q[$];
  resp_t         rd_q[$];
  int            cyc, checks, errors;
  int            idle_at, acc_at, acc_m, m_last;
  int            want[NREQ];
  logic          pend[NREQ];
  logic [CW-1:0] pcmd[NREQ];
  logic [AW-1:0] paddr[NREQ];
  logic [DW-1:0] pwdata[NREQ];
  logic          force_en;
  logic [DW-1:0] force_rd;
  logic [CW-1:0] h_cmd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic raise(input int m, input logic [CW-1:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] w);
    pend[m]   = 1'b1;
    pcmd[m]   = c;
    paddr[m]  = a;
    pwdata[m] = w;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (acc_at == cyc) pend[acc_m] = 1'b0;
    if (rd_q.size() > 0 && rd_q[0].cyc == 32'(cyc)) begin
      lb_rdata = rd_q[0].data;
      void'(rd_q.pop_front());
    end else begin
      lb_rdata = $urandom;
    end
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && !rst && int'($urandom_range(0, 99)) < want[i])
        raise(i, CW'($urandom), AW'($urandom), $urandom);
  endtask

  // Reference: grant the first pending master after the previous winner;
  // a write occupies 3 cycles, a read RDLAT+3 cycles, before the next grant.
  task automatic grant_model(input int g);
    logic [DW-1:0] d;
    m_last = g;
    acc_m  = g;
    acc_at = cyc + 2;
    stb_q.push_back('{32'(cyc + 1), 8'(g), pcmd[g], paddr[g], pwdata[g]});
    if (pcmd[g][0]) begin
      d = force_en ? force_rd : $urandom;
      force_en = 1'b0;
      rd_q.push_back('{32'(cyc + 1 + RDLAT), 8'd0, d});
      resp_q.push_back('{32'(cyc + 2 + RDLAT), 8'(g), d});
      idle_at = cyc + 3 + RDLAT;
    end else begin
      resp_q.push_back('{32'(cyc + 2), 8'(g), {DW{1'b0}}});
      idle_at = cyc + 3;
    end
  endtask

  task automatic end_cycle();
    int g, c;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = pend[i];
      req_cmd[i*CW +: CW]     = pcmd[i];
      req_addr[i*AW +: AW]    = paddr[i];
      req_wdata[i*DW +: DW]   = pwdata[i];
    end
    if (!rst && cyc >= idle_at) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (g < 0 && pend[c]) g = c;
      end
      if (g >= 0) grant_model(g);
    end
  endtask

  task automatic tick();
    begin_cycle();
    end_cycle();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    stb_q.delete();
    resp_q.delete();
    rd_q.delete();
    m_last = NREQ - 1;
    acc_at = -1;
    repeat (n) tick();
    begin_cycle();
    rst     = 1'b0;
    idle_at = cyc;
    end_cycle();
  endtask

  task automatic wait_quiet();
    int guard;
    logic busy;
    guard = 0;
    busy  = 1'b1;
    while (busy && guard < 200) begin
      busy = (cyc + 1 < idle_at);
      for (int i = 0; i < NREQ; i++) if (pend[i]) busy = 1'b1;
      if (busy) tick();
      guard++;
    end
    if (busy) chk("wait_quiet_timeout", 64'(1), 64'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    stb_t            se;
    resp_t           re;
    logic            exp_stb;
    logic [NREQ-1:0] exp_rdy, exp_vld;
    if (rst) begin
      chk("rst_ctrl", 64'({lb_stb, req_ready, resp_valid}), 64'(0));
      chk("rst_rdata", 64'(resp_rdata), 64'(0));
      chk("rst_cmd_addr", 64'({lb_cmd, lb_addr}), 64'(0));
      chk("rst_wdata", 64'(lb_wdata), 64'(0));
      h_cmd   = '0;
      h_addr  = '0;
      h_wdata = '0;
    end else begin
      exp_stb = 1'b0;
      exp_rdy = '0;
      exp_vld = '0;
      if (stb_q.size() > 0 && stb_q[0].cyc == 32'(cyc)) begin
        se      = stb_q.pop_front();
        exp_stb = 1'b1;
        exp_rdy = NREQ'(1) << se.m;
        h_cmd   = se.cmd;
        h_addr  = se.addr;
        h_wdata = se.wdata;
      end
      chk("lb_stb", 64'(lb_stb), 64'(exp_stb));
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("lb_cmd", 64'(lb_cmd), 64'(h_cmd));
      chk("lb_addr", 64'(lb_addr), 64'(h_addr));
      chk("lb_wdata", 64'(lb_wdata), 64'(h_wdata));
      if (resp_q.size() > 0 && resp_q[0].cyc == 32'(cyc)) begin
        re      = resp_q.pop_front();
        exp_vld = NREQ'(1) << re.m;
        chk("resp_rdata", 64'(resp_rdata), 64'(re.data));
      end
      chk("resp_valid", 64'(resp_valid), 64'(exp_vld));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; checks = 0; errors = 0;
    idle_at = 0; acc_at = -1; acc_m = 0; m_last = NREQ - 1;
    force_en = 1'b0; force_rd = '0;
    h_cmd = '0; h_addr = '0; h_wdata = '0;
    req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0; lb_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      want[i] = 0; pend[i] = 1'b0; pcmd[i] = '0; paddr[i] = '0; pwdata[i] = '0;
    end
    rst = 1'b0;
    #1;
    apply_reset(3);

    // single write from master 0, then single read from master 1
    begin_cycle();
    raise(0, 8'h00, 24'h000010, 32'hDEADBEEF);
    end_cycle();
    wait_quiet();
    begin_cycle();
    force_en = 1'b1;
    force_rd = 32'h12345678;
    raise(1, 8'h01, 24'h000020, 32'h0);
    end_cycle();
    wait_quiet();
    repeat (2) tick();

    // masters 0 and 1 held continuously right after reset
    apply_reset(2);
    want[0] = 100; want[1] = 100;
    repeat (30) tick();

    // masters 0 and 2 continuous, master 1 joins later
    want[1] = 0; want[2] = 100;
    repeat (24) tick();
    want[1] = 100;
    repeat (24) tick();

    // random traffic
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NREQ; i++) want[i] = int'($urandom_range(0, 70));
      repeat (50) tick();
    end

    // reset during WAIT of a read, with a request raised and withdrawn meanwhile
    for (int i = 0; i < NREQ; i++) want[i] = 0;
    wait_quiet();
    begin_cycle();
    raise(2, 8'h01, 24'h000400, 32'h0);
    end_cycle();
    tick();
    begin_cycle();
    raise(1, 8'h00, 24'h000500, 32'hCAFEF00D);
    end_cycle();
    begin_cycle();
    pend[1] = 1'b0;
    end_cycle();
    tick();
    apply_reset(2);
    begin_cycle();
    raise(0, 8'h00, 24'h000030, 32'h0BADF00D);
    raise(1, 8'h00, 24'h000031, 32'h600DCAFE);
    end_cycle();
    wait_quiet();

    // drain and confirm nothing expected was left unseen
    repeat (4) tick();
    chk("stb_q_drained", 64'(stb_q.size()), 64'(0));
    chk("resp_q_drained", 64'(resp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Round-robin arbiter that shares the single regmap local bus (8-bit command, 24-bit address, 32-bit data) between NREQ bus masters, such as the UART and UDP command front-ends. It sits between the master front-ends and the `lbreg` register map inside `qubichw_config`. It serialises transactions: one grant at a time, each held until its write completes or its read data returns after the fixed regmap read latency. The grant is then routed back to the granted master only.

## Interface
- NREQ, 2, number of requesters (2..8)
- LBCWIDTH, 8, command width; cmd[0]=1 read, 0 write; other bits passed through
- LBAWIDTH, 24, address width
- LBDWIDTH, 32, data width
- RDLAT, 2, regmap read latency in clocks from lb_stb to lb_rdata valid (>=1)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending per master; held with fields stable until req_ready
- req_cmd  in  NREQ*LBCWIDTH  packed, master i at [i*LBCWIDTH +: LBCWIDTH]
- req_addr  in  NREQ*LBAWIDTH  packed likewise
- req_wdata  in  NREQ*LBDWIDTH  packed likewise
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- resp_valid  out  NREQ  one-cycle completion pulse, one-hot
- resp_rdata  out  LBDWIDTH  read data, valid with resp_valid; 0 for writes
- lb_stb  out  1  one-cycle transaction strobe to regmap
- lb_cmd  out  LBCWIDTH  latched command
- lb_addr  out  LBAWIDTH  latched address
- lb_wdata  out  LBDWIDTH  latched write data
- lb_rdata  in  LBDWIDTH  regmap read data, sampled RDLAT clocks after lb_stb

## Operation
- All outputs are registered. Reset value of every output is 0. Reset puts the FSM in IDLE and sets the round-robin pointer `last` to NREQ-1.
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE: if any req_valid is set, pick grant g = the first requester with valid set, searching from (last+1) mod NREQ upward with wrap. Latch g and master g's cmd/addr/wdata, set last=g, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): lb_stb=1, req_ready[g]=1, lb_cmd/addr/wdata hold the latched values.
  - Write: go to RESP with resp_rdata=0.
  - Read: go to WAIT with the counter loaded to RDLAT-1.
- WAIT: decrement the counter each cycle. When it is 0, sample lb_rdata into resp_rdata and go to RESP. WAIT lasts exactly RDLAT cycles.
- RESP (1 cycle): resp_valid[g]=1, then go to IDLE.
- lb_cmd/addr/wdata keep their last values outside ISSUE. Only lb_stb qualifies them.
- Requests that arrive or are withdrawn while a transaction is outstanding are not accepted. They are only evaluated in IDLE.
- Arbitration with simultaneous requests is strictly round-robin. No master waits more than NREQ-1 transactions.
- Asserting rst mid-transaction (ISSUE/WAIT/RESP) aborts it immediately. No resp_valid is produced, and a read whose strobe was already issued is dropped.
- The regmap is not inspected for errors. Every accepted transaction completes.

## Timing
- Request valid in IDLE at cycle T: lb_stb and req_ready[g] are high at T+1 (S).
- Write: resp_valid at S+1, and IDLE again at S+2. Back-to-back writes give 1 transaction per 3 cycles.
- Read: lb_rdata is sampled at the end of cycle S+RDLAT. resp_valid and resp_rdata are high at S+RDLAT+1.
- The next grant is evaluated in the IDLE cycle after RESP.
- req_ready and resp_valid never assert for more than one master in the same cycle.

## Test plan
- Single write, master 0: cmd=0x00, addr=0x000010, wdata=0xDEADBEEF. Required: lb_stb one cycle with these values, req_ready[0] at T+1, resp_valid[0] at T+2, resp_rdata=0.
- Single read, master 1, RDLAT=3: addr=0x000020, with the regmap model returning 0x12345678 three cycles after the strobe. Required: resp_valid[1] at S+4 with resp_rdata=0x12345678, and req_ready[0] never asserted.
- Both masters valid in the same cycle after reset: master 0 is granted first, then master 1. With both held continuously for 6 transactions, the grant order is 0,1,0,1,0,1.
- NREQ=3, with masters 0 and 2 continuously requesting and master 1 idle: the grant order alternates 0,2,0,2. When master 1 raises valid while 0 is granted, master 1 is granted next.
- rst asserted during WAIT of a read with RDLAT=4: all outputs are 0 immediately, and no resp_valid appears. A subsequent write to master 0 completes normally, with the pointer reset so master 0 wins a tie.
- Master withdraws req_valid before IDLE: no strobe is issued and outputs stay 0.
